// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter states and frame constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full and pop when empty are ignored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 frames
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  tx_state_t state;
  logic [BW-1:0] baud;
  logic [2:0] bit_idx;
  logic [UART_DATA_BITS-1:0] shift_reg, head;
  logic full, empty, pop, bit_end, tx_next;
  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid), .pop(pop), .wdata(in_data),
    .rdata(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign in_ready = !full;
  assign busy = (state != IDLE) || (fifo_count != '0);
  assign bit_end = baud == BW'(CLKS_PER_BIT - 1);
  // Popping in the last STOP cycle chains frames without an idle gap
  assign pop = ena && !empty && (state == IDLE || (state == STOP && bit_end));
`ifdef UART_TX_PARITY_EN
  logic parity;
  assign tx_next = (state == START) ? 1'b0 : (state == DATA) ? shift_reg[0] :
                   (state == PARITY) ? parity : UART_IDLE_LEVEL;
  always_ff @(posedge clk)
    if (rst) parity <= 1'b0;
    else if (pop) parity <= ^head;
`else
  assign tx_next = (state == START) ? 1'b0 : (state == DATA) ? shift_reg[0] : UART_IDLE_LEVEL;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      tx <= UART_IDLE_LEVEL;
    end else begin
      tx <= tx_next;
      baud <= (state == IDLE || bit_end) ? '0 : baud + BW'(1);
      if (pop) begin
        shift_reg <= head;
        state <= START;
      end else if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            bit_idx <= '0;
          end
          DATA: begin
            shift_reg <= shift_reg >> 1;
            bit_idx <= bit_idx + 3'd1;
            state <= (bit_idx == 3'(UART_DATA_BITS - 1)) ? AFTER_DATA : DATA;
          end
          PARITY: state <= STOP;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; a line monitor decodes frames from tx and checks them against queued bytes
module tb_uart_tx_fifo;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FC = NB * CPB;

  logic clk = 1'b0, rst = 1'b1, ena = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, tx, busy;
  logic [2:0] fifo_count;
  int tests = 0, fails = 0, cyc = 0, last_push = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: frame begins at the first low sample; each bit is sampled mid-period
  always begin : mon
    logic [10:0] bits;
    logic [7:0] e;
    bit ab;
    int st;
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      st = cyc;
      ab = 0;
      bits = '1;
      for (int c = 1; c < FC; c++) begin
        @(negedge clk);
        ab |= rst;
        if (c % CPB == CPB / 2) bits[c / CPB] = tx;
      end
      if (!ab) begin
        starts.push_back(st);
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("frame_data", bits[8:1], e);
          check("start_bit", bits[0], 0);
          check("stop_bit", bits[NB-1], 1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", bits[9], ^e);
`endif
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output bit acc);
    @(negedge clk);
    in_data = b;
    in_valid = 1'b1;
    acc = in_ready;
    if (acc) exp_q.push_back(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
    last_push = cyc;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
    repeat (2 * CPB) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit acc;
    int n, nacc, lows;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_count", fifo_count, 0);

    // Single byte latency
    ena = 1'b1;
    push_byte(8'hA5, acc);
    n = last_push;
    @(negedge clk);
    check("busy_after_push", busy, 1);
    check("tx_n0", tx, 1);
    @(negedge clk);
    check("tx_n1", tx, 1);
    @(negedge clk);
    check("tx_fall_n2", tx, 0);
    lows = 0;
    while (busy && lows < 200) begin
      @(negedge clk);
      lows++;
    end
    check("busy_fall_cycle", cyc, n + 1 + FC);
    repeat (2 * CPB) @(negedge clk);
    check("single_drained", exp_q.size(), 0);

    // Back-to-back
    starts.delete();
    push_byte(8'h00, acc);
    push_byte(8'hFF, acc);
    push_byte(8'h55, acc);
    wait_idle(10 * FC);
    check("b2b_frames", starts.size(), 3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], FC);
      check("b2b_gap2", starts[2] - starts[1], FC);
      check("b2b_total", starts[2] + FC - starts[0], 3 * FC);
    end

    // Full FIFO with ena low
    ena = 1'b0;
    nacc = 0;
    for (int i = 1; i <= 5; i++) begin
      push_byte(8'(i), acc);
      nacc += int'(acc);
    end
    check("fifth_rejected", acc, 0);
    check("full_accepted", nacc, 4);
    @(negedge clk);
    check("full_count", fifo_count, 4);
    check("full_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    check("ena_low_no_tx", tx, 1);
    ena = 1'b1;
    @(negedge clk);
    check("in_ready_after_pop", in_ready, 1);
    check("count_after_pop", fifo_count, 3);
    wait_idle(10 * FC);

    // Reset mid-frame
    push_byte(8'h3C, acc);
    push_byte(8'h11, acc);
    push_byte(8'h22, acc);
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_frame_started", int'(n < 50), 1);
    repeat (17) @(negedge clk);
    check("rst_pre_count", fifo_count, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy", busy, 0);
    lows = 0;
    repeat (3 * FC) begin
      @(negedge clk);
      lows += int'(tx !== 1'b1);
    end
    check("rst_no_frames", lows, 0);

`ifdef UART_TX_PARITY_EN
    starts.delete();
    push_byte(8'h07, acc);
    push_byte(8'h03, acc);
    wait_idle(6 * FC);
    check("par_frames", starts.size(), 2);
    if (starts.size() == 2) check("par_frame_len", starts[1] - starts[0], FC);
`endif

    // Randomized traffic with ena toggling
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ena = $urandom_range(0, 3) != 0;
      in_valid = $urandom_range(0, 2) == 0;
      in_data = 8'($urandom);
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ena = 1'b1;
    wait_idle(20 * FC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Downstream consumer of the user project's byte-wide output stream.
- Buffers bytes in a small synchronous FIFO and serialises them as 8N1 UART frames on a single pin, so a Tiny Tapeout project can stream results to a host.
- Sits between the core logic, which drives the parallel byte and valid signal, and a dedicated output pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  design-selected enable; when low, no new frame starts.
- in_data  in  8  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a clk edge.
- tx  out  1  serial line; idles high; registered output.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high) gives:
  - tx=1, busy=0, fifo_count=0, in_ready=1.
  - FSM in IDLE; FIFO pointers cleared; bit and baud counters cleared.
- Reset asserted mid-frame aborts the frame. tx=1 from the next cycle and buffered bytes are discarded.
- FIFO:
  - in_ready = (fifo_count != FIFO_DEPTH), decoded from registered state.
  - Push when in_valid && in_ready. Pop is driven only by the FSM.
  - Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and data ordering is preserved.
  - Push to full is impossible because in_ready=0. Pop from empty never occurs.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: if ena && fifo non-empty, pop the head into shift_reg, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[0] (LSB first). Each bit lasts CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for CLKS_PER_BIT cycles. In the final STOP cycle:
    - if ena && non-empty: pop and go directly to START, giving back-to-back frames with no idle gap;
    - otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Latency:
  - A byte accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
  - tx falls after edge N+2.
  - Frame length is 10*CLKS_PER_BIT cycles (11 with parity).
- ena:
  - Deasserting ena mid-frame does not truncate the frame; it only blocks the next pop.
  - Pushes are accepted regardless of ena.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1, 11 bit periods.
- Undefined:
  - No PARITY state or logic; DATA goes directly to STOP.
  - Frame is 8N1, 10 bit periods.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_DATA_BITS=8 and UART_IDLE_LEVEL=1'b1.
- One sub-module: sync_fifo (parameterised width and depth; push/pop, full/empty, count).
- FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset check: hold rst for 3 cycles -> tx=1, busy=0, in_ready=1, fifo_count=0.
- Single byte: push 0xA5 at edge N -> tx low from N+2. Sequence in 4-cycle bits is 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop). busy falls after the frame.
- Back-to-back: push 0x00,0xFF,0x55 on consecutive cycles -> three contiguous frames, 120 cycles total, no idle cycle between a stop bit and the next start bit.
- Full FIFO: with ena=0, push 5 bytes 0x01..0x05 -> fifo_count=4, in_ready=0, and the 5th byte is not accepted. Then raise ena -> frames 0x01..0x04 in order, and in_ready rises one cycle after the first pop.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C with 2 bytes queued -> tx=1 next cycle, fifo_count=0, no further frames.
- Parity (UART_TX_PARITY_EN defined): 0x07 -> parity bit 1; 0x03 -> parity bit 0; each frame is 44 cycles.
